serial_adder_ctrl: RTL and testbench

Bit-serial add/subtract sequencer that time-shares a single 1-bit FULL_ADDER instance across a WIDTH-bit operation, one bit per clock, LSB first. It latches two operands on a START handshake, steps the full adder WIDTH times while holding the carry in a flip-flop, and returns a WIDTH-bit result with carry and signed-overflow flags. It serves as the low-area arithmetic path next to the parallel ripple adders, for use where gate count matters more than latency.

---
 rtl/serial_adder_ctrl_if.sv | 40 ++++
 rtl/serial_adder_ctrl.sv | 159 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if
//   Operation request/response bundle for the bit-serial add/subtract
//   sequencer. The requester uses the master modport and the sequencer the
//   slave modport.
//
//   start   operation request, only acted on while the sequencer is idle
//   op      0 = a+b, 1 = a-b, sampled together with start
//   a, b    WIDTH-bit operands, sampled together with start
//   result  WIDTH-bit sum/difference, valid while done is high
//   co      carry out of the MSB (for subtract, 1 = no borrow)
//   v       signed overflow
//   busy    high while an operation is in progress
//   done    one-cycle pulse marking result/co/v valid
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = `DATA_WIDTH
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             co;
  logic             v;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  result, co, v, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output result, co, v, busy, done
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial add/subtract sequencer. A single 1-bit full adder is stepped
//   WIDTH times, LSB first, with the carry held in a flip-flop between steps.
//   Operands are latched on a start request seen in IDLE; the result is
//   shifted in from the MSB end and is valid while done pulses.
//
//   Ports:
//     CLK   system clock, rising edge active
//     RST   asynchronous active-low reset
//     bus   serial_adder_ctrl_if slave modport (start/op/a/b in,
//           result/co/v/busy/done out)
//
//   Timing: the start edge E0 moves to RUN, edges E1..EW process bits
//   0..WIDTH-1, the state after EW is FIN (done=1), and edge E(W+1) returns
//   to IDLE. busy is high for exactly WIDTH+1 cycles.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = `DATA_WIDTH
) (
  input logic              CLK,
  input logic              RST,
  serial_adder_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             op_q;
  logic             cr;
  logic             cmsb;
  logic [CNT_W-1:0] cnt;
  logic             co_q;
  logic             v_q;
  logic             busy_q;
  logic             done_q;

  logic fa_b;
  logic fa_s;
  logic fa_co;

  // Subtract is a + ~b + 1: b is inverted bit by bit here and the +1 comes
  // from seeding the carry register with op at the start edge.
  assign fa_b = sb[0] ^ op_q;

  full_adder u_fa (
    .a  (sa[0]),
    .b  (fa_b),
    .ci (cr),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN:  if (cnt == CNT_LAST) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are flopped from the next state so they change together with
  // the state register and have no combinational path from the inputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == FIN);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sa   <= '0;
      sb   <= '0;
      res  <= '0;
      op_q <= 1'b0;
      cr   <= 1'b0;
      cmsb <= 1'b0;
      cnt  <= '0;
      co_q <= 1'b0;
      v_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa   <= bus.a;
            sb   <= bus.b;
            op_q <= bus.op;
            cr   <= bus.op;
            cnt  <= '0;
          end
        end
        RUN: begin
          res <= {fa_s, res[WIDTH-1:1]};
          cr  <= fa_co;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + CNT_W'(1);
          // Carry out of bit WIDTH-2 is the carry into the MSB.
          if (cnt == CNT_PENULT) begin
            cmsb <= fa_co;
          end
          if (cnt == CNT_LAST) begin
            co_q <= fa_co;
            v_q  <= cmsb ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = res;
  assign bus.co     = co_q;
  assign bus.v      = v_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// full_adder
//   1-bit full adder: s = a ^ b ^ ci, co = majority(a, b, ci).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Self-checking bench for serial_adder_ctrl at WIDTH=32: reset values,
//   directed add/subtract corner cases with latency and busy-length checks,
//   start-while-busy, asynchronous reset mid-operation, and 1000 random
//   back-to-back operations with start held high against an arithmetic model.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 32;
  localparam int unsigned P = W + 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {co, v, result}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic op);
    longint unsigned ua, ub, ur;
    longint          sa, sb, sr;
    logic            co, v;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (op) begin
      ur = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      ur = ua + ub;
      co = (ur >= 64'h1_0000_0000);
      sr = sa + sb;
    end
    v = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
    return {co, v, ur[W-1:0]};
  endfunction

  // Runs one operation starting #1 after an edge; checks latency, busy
  // length, result flags and the return to idle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                        input string tag);
    logic [W+1:0] exp;
    int busy_cnt;
    int edges;
    logic got;
    bus.a = a;
    bus.b = b;
    bus.op = op;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy_cnt = bus.busy ? 1 : 0;
    edges = 0;
    got = 1'b0;
    for (int i = 1; i <= 100 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        got = 1'b1;
        edges = i;
      end
    end
    exp = ref_op(a, b, op);
    chk({tag, "_done_seen"}, 64'(got), 64'(1));
    chk({tag, "_latency"}, 64'(edges), 64'(W));
    chk({tag, "_result"}, 64'(bus.result), 64'(exp[W-1:0]));
    chk({tag, "_co"}, 64'(bus.co), 64'(exp[W+1]));
    chk({tag, "_v"}, 64'(bus.v), 64'(exp[W]));
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, 64'(bus.done), 64'(0));
    chk({tag, "_busy_clr"}, 64'(bus.busy), 64'(0));
    chk({tag, "_busy_len"}, 64'(busy_cnt), 64'(W + 1));
  endtask

  initial begin
    logic [W-1:0]  qa[$];
    logic [W-1:0]  qb[$];
    logic          qop[$];
    logic [W+1:0]  exp;
    logic [W-1:0]  cap_res;
    int            dcount;
    int            phase;

    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.a = '0;
    bus.b = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", 64'(bus.result), 64'(0));
    chk("rst_co", 64'(bus.co), 64'(0));
    chk("rst_v", 64'(bus.v), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, "add_basic");
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "add_carry");
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "add_ovf");
    run_op(32'h0000_0003, 32'h0000_0005, 1'b1, "sub_borrow");
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, "sub_ovf");

    // Start request while busy must be ignored.
    bus.a = 32'd1;
    bus.b = 32'd1;
    bus.op = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.a = 32'd9;
    bus.b = 32'd9;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dcount = 0;
    cap_res = '1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        dcount++;
        cap_res = bus.result;
      end
    end
    chk("busy_start_done_cnt", 64'(dcount), 64'(1));
    chk("busy_start_result", 64'(cap_res), 64'(2));

    // Asynchronous reset in the middle of RUN.
    bus.a = 32'h1234_5678;
    bus.b = 32'h1111_1111;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_result", 64'(bus.result), 64'(0));
    chk("arst_co", 64'(bus.co), 64'(0));
    chk("arst_v", 64'(bus.v), 64'(0));
    chk("arst_busy", 64'(bus.busy), 64'(0));
    chk("arst_done", 64'(bus.done), 64'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'd10, 32'd20, 1'b0, "after_rst");

    // Back-to-back with start held high: an op is accepted every P edges.
    bus.a = $urandom();
    bus.b = $urandom();
    bus.op = 1'($urandom_range(0, 1));
    bus.start = 1'b1;
    for (int k = 0; k < 1000 * int'(P); k++) begin
      @(posedge clk);
      phase = k % int'(P);
      if (phase == 0) begin
        qa.push_back(bus.a);
        qb.push_back(bus.b);
        qop.push_back(bus.op);
      end
      #1;
      chk("b2b_done", 64'(bus.done), 64'(phase == int'(W)));
      chk("b2b_busy", 64'(bus.busy), 64'(phase != int'(W) + 1));
      if (bus.done && qa.size() > 0) begin
        exp = ref_op(qa.pop_front(), qb.pop_front(), qop.pop_front());
        chk("b2b_result", 64'(bus.result), 64'(exp[W-1:0]));
        chk("b2b_co", 64'(bus.co), 64'(exp[W+1]));
        chk("b2b_v", 64'(bus.v), 64'(exp[W]));
      end
      bus.a = $urandom();
      bus.b = $urandom();
      bus.op = 1'($urandom_range(0, 1));
    end
    bus.start = 1'b0;
    chk("b2b_queue_empty", 64'(qa.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
